fb_scanout: RTL and testbench

- Reader side of the double-buffered 640x480 frame buffer.
- Generates 640x480@60 VGA timing, one pixel per `clk` (25 MHz pixel clock), and issues read addresses into the front buffer.
- Returns 9-bit RGB333 pixels with sync and data-enable aligned to them.
- Accepts the writer's `swap` toggle and flips the front/back buffer only at the start of vertical blank, so frames never tear.

---
 rtl/fb_scanout.sv | 150 +++++++++++++++
 tb/tb_fb_scanout.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Frame-buffer reader: 640x480@60 VGA timing, front-buffer read addressing and
// a swap handshake that flips buffers only at the first vertical-blank line.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swap,
  output logic        rd_en,
  output logic        rd_buf,
  output logic [18:0] rd_addr,
  input  logic [8:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [8:0]  rgb,
  output logic        swap_ack,
  output logic        overrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [18:0] LINE_W   = 19'(H_ACTIVE);

  logic [9:0]        hcnt_q, hcnt_d;
  logic [9:0]        vcnt_q, vcnt_d;
  logic              buf_sel_q, buf_sel_d;
  logic              pending_q, pending_d;
  logic              swap_prev_q, swap_prev_d;
  logic [RD_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [RD_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic [RD_LAT-1:0] de_pipe_q, de_pipe_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic [8:0]        rgb_q, rgb_d;
  logic              swap_ack_q, swap_ack_d;
  logic              overrun_q, overrun_d;

  logic active, hs0, vs0, swap_chg, commit;

  always_comb begin
    active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    rd_en   = !rst && active;
    rd_addr = rd_en ? (19'(vcnt_q) * LINE_W + 19'(hcnt_q)) : 19'd0;
    rd_buf  = buf_sel_q;
    hs0     = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vs0     = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));

    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  // A toggle seen in the commit cycle itself is folded into that flip.
  always_comb begin
    swap_prev_d = swap;
    swap_chg    = swap ^ swap_prev_q;
    commit      = (hcnt_q == 10'd0) && (vcnt_q == V_ACT);
    buf_sel_d   = buf_sel_q;
    pending_d   = pending_q;
    swap_ack_d  = 1'b0;
    overrun_d   = swap_chg && pending_q;
    if (commit) begin
      if (pending_q || swap_chg) begin
        buf_sel_d  = ~buf_sel_q;
        pending_d  = 1'b0;
        swap_ack_d = 1'b1;
      end
    end else if (swap_chg) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    hs_pipe_d    = hs_pipe_q << 1;
    hs_pipe_d[0] = hs0;
    vs_pipe_d    = vs_pipe_q << 1;
    vs_pipe_d[0] = vs0;
    de_pipe_d    = de_pipe_q << 1;
    de_pipe_d[0] = rd_en;
    hsync_d      = hs_pipe_q[RD_LAT-1];
    vsync_d      = vs_pipe_q[RD_LAT-1];
    de_d         = de_pipe_q[RD_LAT-1];
    rgb_d        = de_pipe_q[RD_LAT-1] ? rd_data : 9'd0;
  end

  // Sync stages reset to their idle (high) level so no false pulse follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q      <= 10'd0;
      vcnt_q      <= 10'd0;
      buf_sel_q   <= 1'b0;
      pending_q   <= 1'b0;
      swap_prev_q <= swap;
      hs_pipe_q   <= '1;
      vs_pipe_q   <= '1;
      de_pipe_q   <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      rgb_q       <= 9'd0;
      swap_ack_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      buf_sel_q   <= buf_sel_d;
      pending_q   <= pending_d;
      swap_prev_q <= swap_prev_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      de_pipe_q   <= de_pipe_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      swap_ack_q  <= swap_ack_d;
      overrun_q   <= overrun_d;
    end
  end

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign de       = de_q;
  assign rgb      = rgb_q;
  assign swap_ack = swap_ack_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: one full-size instance and two shrunken-geometry
// instances (read latency 1 and 3) checked against a position-based model.
module tb_fb_scanout;

  localparam int NI = 3;
  localparam int HA  [NI] = '{640, 16, 16};
  localparam int HF  [NI] = '{16, 4, 4};
  localparam int HS  [NI] = '{96, 6, 6};
  localparam int HB  [NI] = '{48, 6, 6};
  localparam int VA  [NI] = '{480, 12, 12};
  localparam int VF  [NI] = '{10, 2, 2};
  localparam int VS  [NI] = '{2, 2, 2};
  localparam int VB  [NI] = '{33, 3, 3};
  localparam int LAT [NI] = '{1, 1, 3};

  logic clk = 1'b0;
  logic rst;
  logic swap;
  bit   chk_on = 1'b0;

  logic        rd_en_w   [NI];
  logic        rd_buf_w  [NI];
  logic [18:0] rd_addr_w [NI];
  logic [8:0]  rd_data_w [NI];
  logic        hsync_w   [NI];
  logic        vsync_w   [NI];
  logic        de_w      [NI];
  logic [8:0]  rgb_w     [NI];
  logic        ack_w     [NI];
  logic        ovr_w     [NI];

  logic [8:0] dpipe [NI][4];

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  // Frame-buffer contents: low address bits, inverted when buffer 1 is read.
  function automatic logic [8:0] fb_word(input logic [18:0] a, input logic b);
    return a[8:0] ^ {9{b}};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fb_scanout #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .RD_LAT(LAT[g])
    ) u_dut (
      .clk(clk), .rst(rst), .swap(swap),
      .rd_en(rd_en_w[g]), .rd_buf(rd_buf_w[g]), .rd_addr(rd_addr_w[g]),
      .rd_data(rd_data_w[g]),
      .hsync(hsync_w[g]), .vsync(vsync_w[g]), .de(de_w[g]), .rgb(rgb_w[g]),
      .swap_ack(ack_w[g]), .overrun(ovr_w[g])
    );
    assign rd_data_w[g] = dpipe[g][LAT[g]-1];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      dpipe[i][0] <= fb_word(rd_addr_w[i], rd_buf_w[i]);
      for (int k = 1; k < 4; k++) dpipe[i][k] <= dpipe[i][k-1];
    end
  end

  task automatic cmp(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Model: raster position now held, buffer/pending state, and a history of
  // per-pixel outputs indexed by age so latency is just a lookup.
  int          mx [NI];
  int          my [NI];
  bit          mbuf [NI], mpend [NI], mprev [NI], mack [NI], movr [NI];
  bit          hs_h [NI][5];
  bit          vs_h [NI][5];
  bit          de_h [NI][5];
  logic [8:0]  rgb_h [NI][5];

  always @(posedge clk) begin
    bit chg, vis;
    int ht, vt;
    for (int i = 0; i < NI; i++) begin
      ht = HA[i] + HF[i] + HS[i] + HB[i];
      vt = VA[i] + VF[i] + VS[i] + VB[i];
      if (rst) begin
        mx[i] = 0; my[i] = 0; mbuf[i] = 0; mpend[i] = 0; mprev[i] = swap;
        mack[i] = 0; movr[i] = 0;
        for (int k = 0; k < 5; k++) begin
          hs_h[i][k] = 1; vs_h[i][k] = 1; de_h[i][k] = 0; rgb_h[i][k] = 9'd0;
        end
      end else begin
        for (int k = 4; k > 0; k--) begin
          hs_h[i][k] = hs_h[i][k-1]; vs_h[i][k] = vs_h[i][k-1];
          de_h[i][k] = de_h[i][k-1]; rgb_h[i][k] = rgb_h[i][k-1];
        end
        vis = (mx[i] < HA[i]) && (my[i] < VA[i]);
        hs_h[i][0]  = !(mx[i] >= HA[i] + HF[i] && mx[i] < HA[i] + HF[i] + HS[i]);
        vs_h[i][0]  = !(my[i] >= VA[i] + VF[i] && my[i] < VA[i] + VF[i] + VS[i]);
        de_h[i][0]  = vis;
        rgb_h[i][0] = vis ? fb_word(19'(my[i] * HA[i] + mx[i]), mbuf[i]) : 9'd0;
        chg = (swap != mprev[i]);
        mack[i] = 0;
        movr[i] = chg && mpend[i];
        if (mx[i] == 0 && my[i] == VA[i]) begin
          if (mpend[i] || chg) begin
            mbuf[i] = !mbuf[i]; mpend[i] = 0; mack[i] = 1;
          end
        end else if (chg) begin
          mpend[i] = 1;
        end
        mprev[i] = swap;
        mx[i] = mx[i] + 1;
        if (mx[i] == ht) begin
          mx[i] = 0;
          my[i] = (my[i] + 1 == vt) ? 0 : my[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          een;
    logic [18:0] eaddr;
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        een   = !rst && (mx[i] < HA[i]) && (my[i] < VA[i]);
        eaddr = een ? 19'(my[i] * HA[i] + mx[i]) : 19'd0;
        cmp("rd_en",    i, 32'(rd_en_w[i]),   32'(een));
        cmp("rd_addr",  i, 32'(rd_addr_w[i]), 32'(eaddr));
        cmp("rd_buf",   i, 32'(rd_buf_w[i]),  32'(mbuf[i]));
        cmp("hsync",    i, 32'(hsync_w[i]),   32'(hs_h[i][LAT[i]]));
        cmp("vsync",    i, 32'(vsync_w[i]),   32'(vs_h[i][LAT[i]]));
        cmp("de",       i, 32'(de_w[i]),      32'(de_h[i][LAT[i]]));
        cmp("rgb",      i, 32'(rgb_w[i]),     32'(rgb_h[i][LAT[i]]));
        cmp("swap_ack", i, 32'(ack_w[i]),     32'(mack[i]));
        cmp("overrun",  i, 32'(ovr_w[i]),     32'(movr[i]));
      end
    end
  end

  initial begin
    int hs_first, hs_low, de_cnt0, vs_first1, vs_first3, vs_low1, de_cnt1;
    int ack_pre, ovr_pre, ack_post;
    hs_first = -1; vs_first1 = -1; vs_first3 = -1;
    hs_low = 0; de_cnt0 = 0; vs_low1 = 0; de_cnt1 = 0;
    ack_pre = 0; ovr_pre = 0; ack_post = 0;

    rst = 1'b1;
    swap = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst_hsync",  0, 32'(hsync_w[0]), 32'd1);
    cmp("rst_vsync",  0, 32'(vsync_w[0]), 32'd1);
    cmp("rst_de",     0, 32'(de_w[0]),    32'd0);
    cmp("rst_rgb",    0, 32'(rgb_w[0]),   32'd0);
    cmp("rst_rd_en",  0, 32'(rd_en_w[0]), 32'd0);
    cmp("rst_ack",    0, 32'(ack_w[0]),   32'd0);
    cmp("rst_ovr",    0, 32'(ovr_w[0]),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // t counts cycles since reset release; small frame = 19 lines x 32 = 608.
    for (int t = 0; t <= 3400; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      case (t)
        704, 1280, 1344, 2208, 2528: swap = ~swap;
        2688: rst = 1'b1;
        2690: rst = 1'b0;
        default: ;
      endcase
      @(negedge clk);

      if (t < 800) begin
        if (!hsync_w[0]) begin
          if (hs_first < 0) hs_first = t;
          hs_low++;
        end
        if (de_w[0]) de_cnt0++;
      end
      if (t < 608) begin
        if (!vsync_w[1]) begin
          if (vs_first1 < 0) vs_first1 = t;
          vs_low1++;
        end
        if (!vsync_w[2] && vs_first3 < 0) vs_first3 = t;
        if (de_w[1]) de_cnt1++;
      end
      if (t < 2688) begin
        if (ack_w[1]) ack_pre++;
        if (ovr_w[1]) ovr_pre++;
      end
      if (t >= 2690 && ack_w[1]) ack_post++;

      case (t)
        0: begin
          cmp("lit_first_en",   0, 32'(rd_en_w[0]),   32'd1);
          cmp("lit_first_addr", 0, 32'(rd_addr_w[0]), 32'd0);
          cmp("lit_first_buf",  0, 32'(rd_buf_w[0]),  32'd0);
        end
        69:   cmp("lit_addr_x5y2", 1, 32'(rd_addr_w[1]), 32'd37);
        71:   cmp("lit_rgb_lat1",  1, 32'(rgb_w[1]),     32'd37);
        73:   cmp("lit_rgb_lat3",  2, 32'(rgb_w[2]),     32'd37);
        992:  cmp("lit_buf_pre",   1, 32'(rd_buf_w[1]),  32'd0);
        993: begin
          cmp("lit_ack_flip1", 1, 32'(ack_w[1]),    32'd1);
          cmp("lit_buf_flip1", 1, 32'(rd_buf_w[1]), 32'd1);
        end
        1345: cmp("lit_overrun",   1, 32'(ovr_w[1]),     32'd1);
        1605: cmp("lit_addr_1285", 0, 32'(rd_addr_w[0]), 32'd1285);
        1607: cmp("lit_rgb_105",   0, 32'(rgb_w[0]),     32'h105);
        2209: begin
          cmp("lit_ack_commit", 1, 32'(ack_w[1]),    32'd1);
          cmp("lit_ovr_commit", 1, 32'(ovr_w[1]),    32'd0);
          cmp("lit_buf_commit", 1, 32'(rd_buf_w[1]), 32'd1);
        end
        2690: begin
          cmp("lit_rst_addr", 1, 32'(rd_addr_w[1]), 32'd0);
          cmp("lit_rst_en",   1, 32'(rd_en_w[1]),   32'd1);
          cmp("lit_rst_buf",  1, 32'(rd_buf_w[1]),  32'd0);
        end
        3075: cmp("lit_no_flip", 1, 32'(rd_buf_w[1]), 32'd0);
        default: ;
      endcase
    end

    cmp("hsync_first_low", 0, 32'(hs_first),  32'd658);
    cmp("hsync_low_len",   0, 32'(hs_low),    32'd96);
    cmp("de_per_line",     0, 32'(de_cnt0),   32'd640);
    cmp("vsync_first_l1",  1, 32'(vs_first1), 32'd450);
    cmp("vsync_first_l3",  2, 32'(vs_first3), 32'd452);
    cmp("vsync_low_len",   1, 32'(vs_low1),   32'd64);
    cmp("de_per_frame",    1, 32'(de_cnt1),   32'd192);
    cmp("ack_count",       1, 32'(ack_pre),   32'd3);
    cmp("overrun_count",   1, 32'(ovr_pre),   32'd1);
    cmp("ack_after_rst",   1, 32'(ack_post),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
